dds_cmd_sender: RTL and testbench

// - Host-side initiator of the DDS serial command protocol: turns a 32-bit tuning word m and an enable

---
 rtl/dds_cmd_sender_if.sv | 28 ++
 rtl/dds_cmd_sender.sv | 227 ++++++++++++++++++++++
 tb/tb_dds_cmd_sender.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dds_cmd_sender_if.sv
//------------------------------------------------------------------------------
// dds_cmd_sender_if : host command side and UART transmit side of dds_cmd_sender
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface dds_cmd_sender_if;
  logic        start;
  logic [31:0] m_in;
  logic        en_req;
  logic        busy;
  logic        done;
  logic        transmit;
  logic [7:0]  tx_byte;
  logic        tx_busy;

  modport master (
    input  start, m_in, en_req, tx_busy,
    output busy, done, transmit, tx_byte
  );

  modport slave (
    output start, m_in, en_req, tx_busy,
    input  busy, done, transmit, tx_byte
  );
endinterface

`default_nettype wire

// File: rtl/dds_cmd_sender.sv
//------------------------------------------------------------------------------
// dds_cmd_sender : sends BYTE0..3/data pairs, SET and optional ENABLE to a UART.
// Option macro DDS_SKIP_UNCHANGED_EN : skip byte lanes equal to the last value sent.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

// Command codes normally come from commands.vh; these defaults apply when it is absent.
`ifndef BYTE0
`define BYTE0  8'hB0
`endif
`ifndef BYTE1
`define BYTE1  8'hB1
`endif
`ifndef BYTE2
`define BYTE2  8'hB2
`endif
`ifndef BYTE3
`define BYTE3  8'hB3
`endif
`ifndef SET
`define SET    8'h53
`endif
`ifndef ENABLE
`define ENABLE 8'h45
`endif

module dds_cmd_sender #(
  parameter int GAP_CYCLES  = 10,
  parameter bit SEND_ENABLE = 1'b1
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  dds_cmd_sender_if.master cmd
);

  localparam int              c_GW      = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [c_GW-1:0] c_GAP_MAX = c_GW'(GAP_CYCLES);

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_LOAD = 3'd1;
  localparam logic [2:0] c_SEND = 3'd2;
  localparam logic [2:0] c_WAIT = 3'd3;
  localparam logic [2:0] c_GAP  = 3'd4;
  localparam logic [2:0] c_FIN  = 3'd5;

  logic [2:0]      state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [3:0]      last_q, last_d;
  logic [c_GW-1:0] gap_q, gap_d;
  logic            first_q, first_d;
  logic [31:0]     m_q, m_d;
  logic            en_q, en_d;
  logic            busy_q, busy_d;
  logic            transmit_q, transmit_d;
  logic [7:0]      tx_byte_q, tx_byte_d;

  logic [3:0]      w_skip;
  logic [3:0]      w_first;
  logic [3:0]      w_next;
  logic [7:0]      w_byte;

`ifdef DDS_SKIP_UNCHANGED_EN
  logic [31:0] cache_q, cache_d;
  logic [3:0]  valid_q, valid_d;

  always_comb begin
    for (int l = 0; l < 4; l++) begin
      w_skip[l] = valid_q[l] && (cache_q[8*l +: 8] == m_q[8*l +: 8]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_q <= 32'h0;
      valid_q <= 4'h0;
    end else begin
      cache_q <= cache_d;
      valid_q <= valid_d;
    end
  end
`else
  assign w_skip = 4'h0;
`endif

  // Lane l occupies indices 2l (command) and 2l+1 (data); a lane is skipped as a pair.
  always_comb begin
    w_first = 4'd8;
    w_next  = idx_q + 4'd1;
    for (int l = 3; l >= 0; l--) begin
      if (!w_skip[l]) w_first = {1'b0, 2'(l), 1'b0};
    end
    if (idx_q[0] && !idx_q[3]) begin
      w_next = 4'd8;
      for (int l = 3; l >= 0; l--) begin
        if ((2'(l) > idx_q[2:1]) && !w_skip[l]) w_next = {1'b0, 2'(l), 1'b0};
      end
    end
  end

  always_comb begin
    case (idx_q)
      4'd0:    w_byte = `BYTE0;
      4'd1:    w_byte = m_q[7:0];
      4'd2:    w_byte = `BYTE1;
      4'd3:    w_byte = m_q[15:8];
      4'd4:    w_byte = `BYTE2;
      4'd5:    w_byte = m_q[23:16];
      4'd6:    w_byte = `BYTE3;
      4'd7:    w_byte = m_q[31:24];
      4'd8:    w_byte = `SET;
      4'd9:    w_byte = `ENABLE;
      default: w_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    last_d     = last_q;
    gap_d      = gap_q;
    first_d    = first_q;
    m_d        = m_q;
    en_d       = en_q;
    busy_d     = busy_q;
    transmit_d = 1'b0;
    tx_byte_d  = tx_byte_q;
`ifdef DDS_SKIP_UNCHANGED_EN
    cache_d    = cache_q;
    valid_d    = valid_q;
`endif
    case (state_q)
      c_IDLE: begin
        if (cmd.start) begin
          m_d     = cmd.m_in;
          en_d    = cmd.en_req;
          busy_d  = 1'b1;
          state_d = c_LOAD;
        end
      end
      c_LOAD: begin
        idx_d   = w_first;
        last_d  = (SEND_ENABLE && en_q) ? 4'd9 : 4'd8;
        state_d = c_SEND;
      end
      c_SEND: begin
        if (!cmd.tx_busy) begin
          tx_byte_d  = w_byte;
          transmit_d = 1'b1;
          first_d    = 1'b1;
          state_d    = c_WAIT;
`ifdef DDS_SKIP_UNCHANGED_EN
          if (idx_q[0] && !idx_q[3]) begin
            for (int l = 0; l < 4; l++) begin
              if (idx_q[2:1] == 2'(l)) begin
                cache_d[8*l +: 8] = w_byte;
                valid_d[l]        = 1'b1;
              end
            end
          end
`endif
        end
      end
      c_WAIT: begin
        // The UART raises tx_busy one cycle after the strobe, so the first cycle is blind.
        if (first_q) begin
          first_d = 1'b0;
        end else if (!cmd.tx_busy) begin
          gap_d   = '0;
          state_d = c_GAP;
        end
      end
      c_GAP: begin
        if (gap_q == c_GAP_MAX) begin
          if (idx_q == last_q) begin
            state_d = c_FIN;
          end else begin
            idx_d   = w_next;
            state_d = c_SEND;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      c_FIN: begin
        busy_d  = 1'b0;
        state_d = c_IDLE;
      end
      default: state_d = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= c_IDLE;
      idx_q      <= 4'd0;
      last_q     <= 4'd0;
      gap_q      <= '0;
      first_q    <= 1'b0;
      m_q        <= 32'h0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      transmit_q <= 1'b0;
      tx_byte_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      gap_q      <= gap_d;
      first_q    <= first_d;
      m_q        <= m_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
      transmit_q <= transmit_d;
      tx_byte_q  <= tx_byte_d;
    end
  end

  // done is decoded from FIN so busy is still high in the done cycle.
  assign cmd.transmit = transmit_q;
  assign cmd.tx_byte  = tx_byte_q;
  assign cmd.busy     = busy_q;
  assign cmd.done     = (state_q == c_FIN);

endmodule

`default_nettype wire

// File: tb/tb_dds_cmd_sender.sv
//------------------------------------------------------------------------------
// tb_dds_cmd_sender : two configurations (GAP 10 / ENABLE on, GAP 0 / ENABLE off)
// driven with random frames and compared against a byte-list model. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_dds_cmd_sender;

  localparam logic [7:0] C_BYTE0  = 8'hB0;
  localparam logic [7:0] C_BYTE1  = 8'hB1;
  localparam logic [7:0] C_BYTE2  = 8'hB2;
  localparam logic [7:0] C_BYTE3  = 8'hB3;
  localparam logic [7:0] C_SET    = 8'h53;
  localparam logic [7:0] C_ENABLE = 8'h45;
`ifdef DDS_SKIP_UNCHANGED_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dds_cmd_sender_if ifa ();
  dds_cmd_sender_if ifb ();

  dds_cmd_sender #(.GAP_CYCLES(10), .SEND_ENABLE(1'b1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .cmd(ifa)
  );
  dds_cmd_sender #(.GAP_CYCLES(0), .SEND_ENABLE(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .cmd(ifb)
  );

  logic        st[2];
  logic [31:0] mi[2];
  logic        er[2];
  logic        stuck[2];
  int          ucnt[2];
  logic        o_tr[2], o_busy[2], o_done[2], o_txb[2];
  logic [7:0]  o_byte[2];

  assign ifa.start   = st[0];
  assign ifa.m_in    = mi[0];
  assign ifa.en_req  = er[0];
  assign ifa.tx_busy = (ucnt[0] > 0) || stuck[0];
  assign ifb.start   = st[1];
  assign ifb.m_in    = mi[1];
  assign ifb.en_req  = er[1];
  assign ifb.tx_busy = (ucnt[1] > 0) || stuck[1];

  assign o_tr[0]   = ifa.transmit;
  assign o_busy[0] = ifa.busy;
  assign o_done[0] = ifa.done;
  assign o_txb[0]  = ifa.tx_busy;
  assign o_byte[0] = ifa.tx_byte;
  assign o_tr[1]   = ifb.transmit;
  assign o_busy[1] = ifb.busy;
  assign o_done[1] = ifb.done;
  assign o_txb[1]  = ifb.tx_busy;
  assign o_byte[1] = ifb.tx_byte;

  // UART model: 100 cycles of tx_busy per accepted byte
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (o_tr[k])          ucnt[k] <= 100;
      else if (ucnt[k] > 0) ucnt[k] <= ucnt[k] - 1;
    end
  end

  // Monitor: per-frame byte capture, idle-gap extremes and pulse counters
  logic [7:0] fb[2][16];
  int         fc[2], idle[2], gmin[2], gmax[2];
  int         ntr[2], ndone[2], dbl[2], dnb[2];
  logic       prv[2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!o_busy[k]) begin
        fc[k]   <= 0;
        idle[k] <= 0;
        gmin[k] <= 100000;
        gmax[k] <= 0;
      end else if (o_tr[k]) begin
        if (fc[k] < 16) fb[k][fc[k]] <= o_byte[k];
        fc[k] <= fc[k] + 1;
        if (fc[k] > 0) begin
          if (idle[k] < gmin[k]) gmin[k] <= idle[k];
          if (idle[k] > gmax[k]) gmax[k] <= idle[k];
        end
        idle[k] <= 0;
      end else if (!o_txb[k]) begin
        idle[k] <= idle[k] + 1;
      end
      if (o_tr[k])              ntr[k]   <= ntr[k] + 1;
      if (o_tr[k] && prv[k])    dbl[k]   <= dbl[k] + 1;
      if (o_done[k])            ndone[k] <= ndone[k] + 1;
      if (o_done[k] && !o_busy[k]) dnb[k] <= dnb[k] + 1;
      prv[k] <= o_tr[k];
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: list of bytes a frame should put on the wire
  logic [7:0]  exp_q[$];
  logic        mvalid[2][4];
  logic [7:0]  mcache[2][4];
  logic [31:0] prev_m[2];
  int          last_fc;

  task automatic model_invalidate();
    for (int k = 0; k < 2; k++)
      for (int l = 0; l < 4; l++) mvalid[k][l] = 1'b0;
  endtask

  task automatic build_exp(input int k, input logic [31:0] m, input logic en);
    exp_q.delete();
    for (int l = 0; l < 4; l++) begin
      logic [7:0] b;
      b = m[8*l +: 8];
      if (!(SKIP && mvalid[k][l] && (mcache[k][l] == b))) begin
        case (l)
          0:       exp_q.push_back(C_BYTE0);
          1:       exp_q.push_back(C_BYTE1);
          2:       exp_q.push_back(C_BYTE2);
          default: exp_q.push_back(C_BYTE3);
        endcase
        exp_q.push_back(b);
        mvalid[k][l] = 1'b1;
        mcache[k][l] = b;
      end
    end
    exp_q.push_back(C_SET);
    if (en && (k == 0)) exp_q.push_back(C_ENABLE);
  endtask

  task automatic run_frame(input int k, input logic [31:0] m, input logic en,
                           input bit intrude, input int hold);
    int nd0, ntr0, lat, low;
    bit got;
    build_exp(k, m, en);
    prev_m[k] = m;
    nd0  = ndone[k];
    ntr0 = ntr[k];
    if (hold > 0) stuck[k] = 1'b1;
    @(negedge clk);
    st[k] = 1'b1; mi[k] = m; er[k] = en;
    @(negedge clk);
    st[k] = 1'b0; mi[k] = $urandom; er[k] = 1'($urandom);
    chk("busy_after_start", 32'(o_busy[k]), 1);
    lat = -1; got = 1'b0; low = 0;
    for (int t = 1; t < 8000 && !got; t++) begin
      @(negedge clk);
      if (lat < 0 && o_tr[k]) lat = t;
      if (o_done[k]) got = 1'b1;
      else if (!o_busy[k]) low++;
      if (intrude && t == 50) begin st[k] = 1'b1; mi[k] = $urandom; er[k] = ~en; end
      if (intrude && t == 51) st[k] = 1'b0;
      if (hold > 0 && t == hold) begin
        chk("stuck_no_tx", 32'(ntr[k] - ntr0), 0);
        chk("stuck_busy", 32'(o_busy[k]), 1);
        stuck[k] = 1'b0;
      end
    end
    chk("done_seen", 32'(got), 1);
    chk("busy_held", 32'(low), 0);
    if (hold == 0) chk("first_latency", 32'(lat), 2);
    last_fc = fc[k];
    chk("n_bytes", 32'(fc[k]), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < 16; i++)
      chk($sformatf("byte%0d", i), 32'(fb[k][i]), 32'(exp_q[i]));
    if (fc[k] > 1) begin
      if (k == 0) chk("gap_ge_10", 32'(gmin[k] >= 10), 1);
      else        chk("gap_le_3", 32'(gmax[k] <= 3), 1);
    end
    // start in the done cycle must be ignored
    if (got) begin st[k] = 1'b1; mi[k] = $urandom; end
    @(negedge clk);
    st[k] = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_after", 32'(o_busy[k]), 0);
    chk("done_count", 32'(ndone[k] - nd0), 1);
    chk("one_cycle_tx", 32'(dbl[k]), 0);
    chk("done_while_idle", 32'(dnb[k]), 0);
  endtask

  task automatic reset_mid_frame();
    int ntr0, t;
    ntr0 = ntr[0];
    @(negedge clk);
    st[0] = 1'b1; mi[0] = $urandom; er[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    for (t = 0; t < 3000 && (ntr[0] - ntr0) < 4; t++) @(negedge clk);
    chk("reach_byte4", 32'((ntr[0] - ntr0) >= 4), 1);
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_transmit", 32'(o_tr[0]), 0);
    chk("rst_busy", 32'(o_busy[0]), 0);
    chk("rst_done", 32'(o_done[0]), 0);
    chk("rst_byte", 32'(o_byte[0]), 0);
    model_invalidate();
    ntr0 = ntr[0];
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (t = 0; t < 300 && o_txb[0]; t++) @(negedge clk);
    chk("no_tx_after_abort", 32'(ntr[0] - ntr0), 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      st[k] = 1'b0; mi[k] = 32'h0; er[k] = 1'b0; stuck[k] = 1'b0; prev_m[k] = 32'h0;
    end
    model_invalidate();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_transmit", 32'(o_tr[k]), 0);
      chk("reset_tx_byte", 32'(o_byte[k]), 0);
      chk("reset_busy", 32'(o_busy[k]), 0);
      chk("reset_done", 32'(o_done[k]), 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_frame(0, 32'h0002672A, 1'b1, 1'b0, 0);
    run_frame(0, 32'h0002672A, 1'b0, 1'b0, 0);
    run_frame(1, 32'h0002672A, 1'b1, 1'b0, 0);
    run_frame(1, 32'h0002672A, 1'b0, 1'b0, 0);
    run_frame(0, 32'h12345678, 1'b1, 1'b1, 0);
    run_frame(0, $urandom, 1'b1, 1'b0, 300);
    reset_mid_frame();
    run_frame(0, 32'h0002672A, 1'b1, 1'b0, 0);
`ifdef DDS_SKIP_UNCHANGED_EN
    run_frame(0, 32'h0002672B, 1'b1, 1'b0, 0);
    chk("skip_len", 32'(last_fc), 4);
`endif
    for (int i = 0; i < 6; i++) begin
      int          k;
      logic [31:0] m;
      k = int'($urandom_range(0, 1));
      if (i % 2 == 1) m = prev_m[k] ^ (32'h1 << (8 * $urandom_range(0, 3)));
      else            m = $urandom;
      run_frame(k, m, 1'($urandom), 1'($urandom), 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire
